// File: rtl/axil_bram_if.sv
// AXI4-Lite channel bundle for the BRAM slave.
// The slave modport is used by axil_bram_slave; the master modport serves the driving side.
interface axil_bram_if #(
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [31:0]       awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [31:0]       araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_bram_slave.sv
// AXI4-Lite slave in front of a single inferred block RAM.
// AW and W are held independently; reads are read-first and may issue back to back.
module axil_bram_slave #(
  parameter int          DATA_W         = 32,
  parameter int          MEM_SIZE_BYTES = 8192,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter string       INIT_FILE      = ""
) (
  input logic        clk,
  input logic        rst_n,
  axil_bram_if.slave bus
);

  localparam int          STRB_W = DATA_W / 8;
  localparam int          LSB    = $clog2(STRB_W);
  localparam int          DEPTH  = MEM_SIZE_BYTES / STRB_W;
  localparam int          IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SIZE   = 32'(MEM_SIZE_BYTES);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q;

  logic              aw_full;
  logic              w_full;
  logic [31:0]       aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic              rd_ok;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [31:0]       wr_off;
  logic [31:0]       rd_off;
  logic              wr_in_range;
  logic              rd_in_range;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign bus.awready = !aw_full;
  assign bus.wready  = !w_full;
  assign bus.arready = !rvalid_q || bus.rready;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  // rd_ok masks the raw array output so reset and SLVERR reads present zero
  assign bus.rdata   = rd_ok ? mem_q : '0;

  assign aw_hs  = bus.awvalid && !aw_full;
  assign w_hs   = bus.wvalid && !w_full;
  assign ar_hs  = bus.arvalid && bus.arready;
  assign commit = aw_full && w_full && !bvalid_q;

  assign wr_off      = aw_addr_q - BASE_ADDR;
  assign rd_off      = bus.araddr - BASE_ADDR;
  assign wr_in_range = wr_off < SIZE;
  assign rd_in_range = rd_off < SIZE;
  assign wr_idx      = wr_off[LSB +: IDX_W];
  assign rd_idx      = rd_off[LSB +: IDX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= bus.awaddr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= bus.wdata;
        w_strb_q <= bus.wstrb;
      end
      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? OKAY : SLVERR;
      end else if (bvalid_q && bus.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rd_ok    <= 1'b0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_in_range ? OKAY : SLVERR;
      rd_ok    <= rd_in_range;
    end else if (bus.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Write and read share one edge so a same-word collision returns the old word.
  always_ff @(posedge clk) begin
    if (commit && wr_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) mem[wr_idx][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
    if (ar_hs) mem_q <= mem[rd_idx];
  end

endmodule

// File: tb/tb_axil_bram_slave.sv
// Randomised bench for axil_bram_slave against a word-array reference model.
// Directed sequences cover ordering, back-pressure, collisions and reset mid-write.
module tb_axil_bram_slave;

  localparam int          DATA_W = 32;
  localparam logic [31:0] MEM    = 32'd1024;
  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam int          DEPTH  = 256;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] model [DEPTH];

  axil_bram_if #(.DATA_W(DATA_W)) bus ();

  axil_bram_slave #(
    .DATA_W(DATA_W),
    .MEM_SIZE_BYTES(1024),
    .BASE_ADDR(BASE),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < MEM;
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (in_rng(a)) return model[widx(a)];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a)) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return BASE - 32'($urandom_range(1, 64));
    if (r == 1) return BASE + MEM + 32'($urandom_range(0, 255));
    return BASE + 32'($urandom_range(0, 1023));
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_hs, w_hs;
    int c;
    aw_done = 0;
    w_done  = 0;
    c       = 0;
    bus.awaddr = a;
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.bready = 1'b1;
    while (!(aw_done && w_done) && c < 40) begin
      bus.awvalid = !aw_done && (c >= aw_dly);
      bus.wvalid  = !w_done && (c >= w_dly);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      step(1);
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      c++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check("wr_accept_timeout", 1'b0, 1'b1);
      return;
    end
    check("bvalid_early", bus.bvalid, 1'b0);
    step(1);
    check("bvalid_latency", bus.bvalid, 1'b1);
    check("bresp", bus.bresp, in_rng(a) ? 2'b00 : 2'b10);
    step(1);
    check("bvalid_clear", bus.bvalid, 1'b0);
    model_write(a, d, s);
  endtask

  task automatic do_read(input logic [31:0] a, input int rr_dly, output logic [31:0] d);
    int c;
    logic [31:0] e;
    e = exp_rd(a);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    c = 0;
    while (!bus.arready && c < 40) begin
      step(1);
      c++;
    end
    step(1);
    bus.arvalid = 1'b0;
    d = bus.rdata;
    check("rvalid_latency", bus.rvalid, 1'b1);
    check("rdata", bus.rdata, e);
    check("rresp", bus.rresp, in_rng(a) ? 2'b00 : 2'b10);
    if (rr_dly > 0) begin
      step(rr_dly);
      check("rdata_hold", bus.rdata, e);
      check("rvalid_hold", bus.rvalid, 1'b1);
    end
    bus.rready = 1'b1;
    step(1);
    bus.rready = 1'b0;
    check("rvalid_clear", bus.rvalid, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_bvalid"}, bus.bvalid, 1'b0);
    check({tag, "_rvalid"}, bus.rvalid, 1'b0);
    check({tag, "_bresp"}, bus.bresp, 2'b00);
    check({tag, "_rresp"}, bus.rresp, 2'b00);
    check({tag, "_rdata"}, bus.rdata, 32'h0);
    check({tag, "_awready"}, bus.awready, 1'b1);
    check({tag, "_wready"}, bus.wready, 1'b1);
    check({tag, "_arready"}, bus.arready, 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    check_idle("reset");

    // Test 1: AW and W together, then readback
    do_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(BASE + 32'h10, 0, d);
    check("t1_rdata", d, 32'hDEADBEEF);

    // Fill the rest of the array with known data
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 4) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0);
    end

    // Test 2: W ahead of AW, single byte lane
    bus.bready = 1'b1;
    bus.wdata  = 32'h0000AB00;
    bus.wstrb  = 4'h2;
    bus.wvalid = 1'b1;
    step(1);
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_held", bus.wready, 1'b0);
      check("t2_no_bvalid", bus.bvalid, 1'b0);
      step(1);
    end
    bus.awaddr  = BASE + 32'h10;
    bus.awvalid = 1'b1;
    step(1);
    bus.awvalid = 1'b0;
    check("t2_bvalid_early", bus.bvalid, 1'b0);
    step(1);
    check("t2_bvalid", bus.bvalid, 1'b1);
    check("t2_bresp", bus.bresp, 2'b00);
    step(1);
    model_write(BASE + 32'h10, 32'h0000AB00, 4'h2);
    do_read(BASE + 32'h10, 0, d);
    check("t2_rdata", d, 32'hDEADABEF);

    // Test 3: out-of-range write and read
    do_write(BASE + MEM, 32'hCAFEF00D, 4'hF, 0, 0);
    do_read(BASE + MEM, 0, d);
    check("t3_rdata_oob", d, 32'h0);
    do_read(BASE, 0, d);

    // Test 4: second write queued behind a stalled response
    bus.bready  = 1'b0;
    bus.awaddr  = BASE + 32'h40;
    bus.wdata   = 32'hA5A5_0001;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    step(1);
    bus.awaddr = BASE + 32'h44;
    bus.wdata  = 32'hA5A5_0002;
    step(1);
    check("t4_first_bvalid", bus.bvalid, 1'b1);
    step(1);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("t4_awready_full", bus.awready, 1'b0);
    check("t4_wready_full", bus.wready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t4_bvalid_hold", bus.bvalid, 1'b1);
      check("t4_awready_hold", bus.awready, 1'b0);
    end
    bus.bready = 1'b1;
    step(1);
    check("t4_bvalid_gap", bus.bvalid, 1'b0);
    step(1);
    check("t4_second_bvalid", bus.bvalid, 1'b1);
    check("t4_second_bresp", bus.bresp, 2'b00);
    step(1);
    check("t4_bvalid_clear", bus.bvalid, 1'b0);
    model_write(BASE + 32'h40, 32'hA5A5_0001, 4'hF);
    model_write(BASE + 32'h44, 32'hA5A5_0002, 4'hF);
    do_read(BASE + 32'h40, 0, d);
    check("t4_rdata_first", d, 32'hA5A5_0001);
    do_read(BASE + 32'h44, 0, d);
    check("t4_rdata_second", d, 32'hA5A5_0002);

    // Test 5: back-to-back reads, then rready stall
    bus.rready  = 1'b1;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.araddr = BASE + 32'(4 * i);
      check("t5_arready", bus.arready, 1'b1);
      step(1);
      check("t5_rvalid", bus.rvalid, 1'b1);
      check("t5_rdata", bus.rdata, model[i]);
    end
    bus.araddr = BASE + 32'hC;
    bus.rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t5_arready_stall", bus.arready, 1'b0);
      check("t5_rdata_stable", bus.rdata, model[2]);
      check("t5_rvalid_stall", bus.rvalid, 1'b1);
    end
    bus.rready = 1'b1;
    step(1);
    bus.arvalid = 1'b0;
    check("t5_rdata_next", bus.rdata, model[3]);
    step(1);
    bus.rready = 1'b0;
    check("t5_rvalid_clear", bus.rvalid, 1'b0);

    // Test 6: same-edge read and write of one word
    do_write(BASE + 32'h20, 32'h11111111, 4'hF, 0, 0);
    bus.bready  = 1'b1;
    bus.awaddr  = BASE + 32'h20;
    bus.wdata   = 32'h22222222;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    step(1);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.araddr  = BASE + 32'h20;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    step(1);
    bus.arvalid = 1'b0;
    check("t6_bvalid", bus.bvalid, 1'b1);
    check("t6_rvalid", bus.rvalid, 1'b1);
    check("t6_read_first", bus.rdata, 32'h11111111);
    bus.rready = 1'b1;
    step(1);
    bus.rready = 1'b0;
    model_write(BASE + 32'h20, 32'h22222222, 4'hF);
    do_read(BASE + 32'h20, 0, d);
    check("t6_new_data", d, 32'h22222222);

    // Reset while a write sits in the holding registers
    bus.awaddr  = BASE + 32'h24;
    bus.wdata   = 32'hBAD0BAD0;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    step(1);
    rst_n       = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    check_idle("midrst");
    step(2);
    check("midrst_no_bvalid", bus.bvalid, 1'b0);
    do_read(BASE + 32'h24, 0, d);

    // Randomised mix of writes and reads
    for (int n = 0; n < 300; n++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 2), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
